// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder, one full_adder cell plus carry flop, valid/ready in and out.
// Optional signed-overflow output ovf is built only when ADD_OVF_EN is defined.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADD_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
   logic [CW-1:0] cnt;
   logic carry, fa_s, fa_co;
   full_adder u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(fa_s), .co(fa_co));
   // sum/cout are separate output registers so they only move on entry to DONE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         a_sr      <= '0;
         b_sr      <= '0;
         sum_sr    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
`ifdef ADD_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_sr     <= a;
               b_sr     <= b;
               carry    <= cin;
               cnt      <= '0;
               in_ready <= 1'b0;
               state    <= SHIFT;
            end
            SHIFT: begin
               sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
               carry  <= fa_co;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum       <= {fa_s, sum_sr[WIDTH-1:1]};
                  cout      <= fa_co;
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef ADD_OVF_EN
                  ovf       <= carry ^ fa_co;
`endif
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb_bit_serial_adder: random and directed stimulus checked every cycle against a cycle-count reference model.
// Build with ADD_OVF_EN defined to also exercise the ovf output.
module tb_bit_serial_adder;
   localparam int W = 8;
   logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cin = 0;
   logic [W-1:0] a = 0, b = 0;
   logic in_ready, out_valid, cout;
   logic [W-1:0] sum;
`ifdef ADD_OVF_EN
   logic ovf;
`endif
   int n_chk = 0, n_fail = 0, cyc = 0, lat = 0;
   bit chk_en = 0;
   int phase = 0;
   logic [W:0] m_res = 0;
   logic [W-1:0] m_sum = 0, r_sum = 0;
   logic m_cout = 0, m_ovf = 0, m_ovf_p = 0, r_cout = 0, r_ovf = 0;

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout)
`ifdef ADD_OVF_EN
      , .ovf(ovf)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   function automatic logic sovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      longint s;
      s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
      return (s > 2 ** (W - 1) - 1) || (s < -(2 ** (W - 1)));
   endfunction

   // Reference: phase 0 = idle, 1..W = cycles spent shifting, W+1 = result presented
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         phase = 0; m_sum = 0; m_cout = 0; m_ovf = 0;
      end else if (phase == 0) begin
         if (in_valid) begin
            phase = 1;
            m_res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            m_ovf_p = sovf(a, b, cin);
         end
      end else if (phase <= W) begin
         phase++;
         if (phase == W + 1) begin
            {m_cout, m_sum} = m_res;
            m_ovf = m_ovf_p;
         end
      end else if (out_ready) phase = 0;
   end

   always @(negedge clk) if (chk_en) begin
      chk("outputs {in_ready,out_valid,cout,sum}", {in_ready, out_valid, cout, sum},
          {phase == 0, phase == W + 1, m_cout, m_sum});
`ifdef ADD_OVF_EN
      chk("ovf", ovf, m_ovf);
`endif
   end

   // Called at a negedge; returns at the negedge after the result handshake.
   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int hold);
      int n;
      a = x; b = y; cin = c; in_valid = 1; out_ready = 0;
      n = 0;
      while (!in_ready && n < 40) begin @(negedge clk); n++; end
      if (!in_ready) fail("accept timeout");
      @(negedge clk);
      in_valid = 0;
      n = 1;
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      if (!out_valid) fail("result timeout");
      lat = n; r_sum = sum; r_cout = cout;
`ifdef ADD_OVF_EN
      r_ovf = ovf;
`endif
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
         @(negedge clk);
         chk("hold sum", sum, r_sum);
         chk("hold cout", cout, r_cout);
         chk("hold out_valid", out_valid, 1);
         chk("hold in_ready", in_ready, 0);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0; in_valid = 0;
      chk("idle after release {in_ready,out_valid}", {in_ready, out_valid}, 2'b10);
   endtask

   initial begin
      int n, last, cnt_v;
      logic [W-1:0] x, y;
      logic c;
      repeat (2) @(negedge clk);
      chk_en = 1;
      rst_n = 1;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset sum", sum, 0);
      chk("reset cout", cout, 0);

      op(8'h0F, 8'h01, 0, 0);
      chk("latency 0F+01", lat, W + 1);
      chk("sum 0F+01", {r_cout, r_sum}, 9'h010);
      chk("model 0F+01", {m_cout, m_sum}, 9'h010);
      op(8'hFF, 8'h01, 0, 0);
      chk("sum FF+01", {r_cout, r_sum}, 9'h100);
      chk("model FF+01", {m_cout, m_sum}, 9'h100);
      op(8'hFF, 8'h00, 1, 0);
      chk("sum FF+00+1", {r_cout, r_sum}, 9'h100);
      op(8'h12, 8'h34, 1, 5);
      chk("sum 12+34+1 held", {r_cout, r_sum}, 9'h047);
      chk("model 12+34+1", {m_cout, m_sum}, 9'h047);

      // reset lands on the 4th shift edge of 0xAA+0x55
      a = 8'hAA; b = 8'h55; cin = 0; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      repeat (3) @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      chk("mid-shift reset in_ready", in_ready, 1);
      chk("mid-shift reset out_valid", out_valid, 0);
      chk("mid-shift reset sum", sum, 0);
      chk("mid-shift reset cout", cout, 0);
      cnt_v = 0;
      for (int i = 0; i < W + 4; i++) begin @(negedge clk); cnt_v += int'(out_valid); end
      chk("aborted op never valid", cnt_v, 0);
      op(8'h03, 8'h04, 0, 0);
      chk("sum 03+04", {r_cout, r_sum}, 9'h007);

      // back-to-back with in_valid and out_ready held high
      out_ready = 1; in_valid = 1; last = 0;
      for (int k = 0; k < 3; k++) begin
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         n = 0;
         while (!in_ready && n < 40) begin @(negedge clk); n++; end
         if (!in_ready) fail("b2b accept timeout");
         else begin
            if (k > 0) chk("b2b accept spacing", cyc - last, W + 2);
            last = cyc;
         end
         @(negedge clk);
      end
      in_valid = 0;
      repeat (W + 4) @(negedge clk);
      out_ready = 0;

      for (int k = 0; k < 30; k++) begin
         x = W'($urandom); y = W'($urandom); c = 1'($urandom);
         op(x, y, c, $urandom_range(0, 3));
         chk("random sum", {r_cout, r_sum}, {1'b0, x} + {1'b0, y} + {8'b0, c});
`ifdef ADD_OVF_EN
         chk("random ovf", r_ovf, sovf(x, y, c));
`endif
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

`ifdef ADD_OVF_EN
      op(8'h7F, 8'h01, 0, 0);
      chk("ovf 7F+01 sum", {r_cout, r_sum}, 9'h080);
      chk("ovf 7F+01 ovf", r_ovf, 1);
      op(8'hFF, 8'h01, 0, 0);
      chk("ovf FF+01 cout", r_cout, 1);
      chk("ovf FF+01 ovf", r_ovf, 0);
`endif

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
